// File: rtl/ika2151_timer_pkg.sv
// rtl/ika2151_timer_pkg.sv - shared state encoding and width defaults for IKA2151 timer primitives
package ika2151_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } timer_state_t;

   localparam int TIMER_A_WIDTH = 10;
   localparam int TIMER_B_WIDTH = 8;

endpackage

// File: rtl/primitive_downcounter_core.sv
// rtl/primitive_downcounter_core.sv - down-counter register, NCEN-sampled zero detect and borrow term
module primitive_downcounter_core
   import ika2151_timer_pkg::*;
#(
   parameter int WIDTH = TIMER_A_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pcen_n,
   input  logic             i_ncen_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   input  logic             i_cnt,
   input  logic             i_run,
   output logic [WIDTH-1:0] o_q,
   output logic             o_bo
);

   logic [WIDTH-1:0] counter_q, counter_d;
   logic             zero_q, zero_d;

   always_comb begin
      counter_d = counter_q;
      zero_d    = zero_q;
      if (!i_pcen_n) begin
         if (i_load) begin
            counter_d = i_load_val;
         end else if (i_dec && (counter_q != '0)) begin
            counter_d = counter_q - {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
      // Samples the pre-update count so borrow spans one full NCEN-to-NCEN window
      if (!i_ncen_n) begin
         zero_d = (counter_q == '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         counter_q <= '0;
         zero_q    <= 1'b0;
      end else begin
         counter_q <= counter_d;
         zero_q    <= zero_d;
      end
   end

   assign o_q  = counter_q;
   assign o_bo = zero_q & i_cnt & i_run;

endmodule

// File: rtl/primitive_downcounter_timer.sv
// rtl/primitive_downcounter_timer.sv - loadable down-counting timer with borrow, flag and IRQ (snapshot: IKA2151_DOWNCNT_SNAPSHOT_EN)
module primitive_downcounter_timer
   import ika2151_timer_pkg::*;
#(
   parameter int WIDTH = TIMER_A_WIDTH
) (
   input  logic             i_EMUCLK,
   input  logic             i_RST,
   input  logic             i_PCEN_n,
   input  logic             i_NCEN_n,
   input  logic             i_CNT,
   input  logic             i_LD,
   input  logic [WIDTH-1:0] i_D,
   input  logic             i_START,
   input  logic             i_STOP,
   input  logic             i_AUTORELOAD,
   input  logic             i_IRQ_EN,
   input  logic             i_FLAG_CLR,
   output logic [WIDTH-1:0] o_Q,
   output logic             o_BO,
   output logic             o_RUN,
   output logic             o_FLAG,
   output logic             o_IRQ_n
`ifdef IKA2151_DOWNCNT_SNAPSHOT_EN
   ,
   input  logic             i_SNAP,
   output logic [WIDTH-1:0] o_SNAP
`endif
);

   timer_state_t     state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             flag_q, flag_d;
   logic             run_q, run_d;

   logic             cnt_load;
   logic [WIDTH-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             borrow;
   logic [WIDTH-1:0] cnt_value;

   always_comb begin
      state_d      = state_q;
      reload_d     = reload_q;
      flag_d       = flag_q;
      cnt_load     = 1'b0;
      cnt_load_val = reload_q;
      cnt_dec      = 1'b0;
      borrow       = 1'b0;
      if (!i_PCEN_n) begin
         if (i_LD) begin
            reload_d = i_D;
         end
         case (state_q)
            ST_IDLE: begin
               if (i_START && !i_STOP) begin
                  state_d = ST_ARM;
               end
            end
            ST_ARM: begin
               cnt_load     = 1'b1;
               cnt_load_val = i_LD ? i_D : reload_q;
               state_d      = i_STOP ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
               if (i_STOP) begin
                  state_d = ST_IDLE;
               end else if (i_START) begin
                  state_d = ST_ARM;
               end else if (i_CNT) begin
                  if (cnt_value != '0) begin
                     cnt_dec = 1'b1;
                  end else begin
                     // One-shot expiry leaves the counter parked at zero
                     borrow = 1'b1;
                     if (i_AUTORELOAD) begin
                        cnt_load = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (i_FLAG_CLR) begin
            flag_d = 1'b0;
         end else if (borrow && i_IRQ_EN) begin
            flag_d = 1'b1;
         end
      end
      run_d = (state_d == ST_RUN);
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         state_q  <= ST_IDLE;
         reload_q <= '0;
         flag_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         flag_q   <= flag_d;
         run_q    <= run_d;
      end
   end

   primitive_downcounter_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .i_clk      (i_EMUCLK),
      .i_rst      (i_RST),
      .i_pcen_n   (i_PCEN_n),
      .i_ncen_n   (i_NCEN_n),
      .i_load     (cnt_load),
      .i_load_val (cnt_load_val),
      .i_dec      (cnt_dec),
      .i_cnt      (i_CNT),
      .i_run      (run_q),
      .o_q        (cnt_value),
      .o_bo       (o_BO)
   );

`ifdef IKA2151_DOWNCNT_SNAPSHOT_EN
   logic [WIDTH-1:0] snap_q, snap_d;

   always_comb begin
      snap_d = snap_q;
      if (!i_PCEN_n && i_SNAP) begin
         snap_d = cnt_value;
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         snap_q <= '0;
      end else begin
         snap_q <= snap_d;
      end
   end

   assign o_SNAP = snap_q;
`endif

   assign o_Q     = cnt_value;
   assign o_RUN   = run_q;
   assign o_FLAG  = flag_q;
   assign o_IRQ_n = ~flag_q;

endmodule

// File: tb/tb_primitive_downcounter_timer.sv
// tb/tb_primitive_downcounter_timer.sv - directed bench with behavioural timer model for primitive_downcounter_timer
module tb_primitive_downcounter_timer;

   localparam int W = 4;

   logic         clk;
   logic         i_RST, i_PCEN_n, i_NCEN_n, i_CNT, i_LD;
   logic [W-1:0] i_D;
   logic         i_START, i_STOP, i_AUTORELOAD, i_IRQ_EN, i_FLAG_CLR;
   logic [W-1:0] o_Q;
   logic         o_BO, o_RUN, o_FLAG, o_IRQ_n;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 0;

   int m_q, m_reload;
   bit m_armed, m_running, m_zero, m_flag;

   primitive_downcounter_timer #(.WIDTH(W)) dut (
      .i_EMUCLK     (clk),
      .i_RST        (i_RST),
      .i_PCEN_n     (i_PCEN_n),
      .i_NCEN_n     (i_NCEN_n),
      .i_CNT        (i_CNT),
      .i_LD         (i_LD),
      .i_D          (i_D),
      .i_START      (i_START),
      .i_STOP       (i_STOP),
      .i_AUTORELOAD (i_AUTORELOAD),
      .i_IRQ_EN     (i_IRQ_EN),
      .i_FLAG_CLR   (i_FLAG_CLR),
      .o_Q          (o_Q),
      .o_BO         (o_BO),
      .o_RUN        (o_RUN),
      .o_FLAG       (o_FLAG),
      .o_IRQ_n      (o_IRQ_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q = 0; m_reload = 0; m_armed = 0; m_running = 0; m_zero = 0; m_flag = 0;
   endtask

   // Timer rules applied to the snapshot of inputs seen at a PCEN edge
   task automatic m_pcen();
      int  old_reload;
      bit  borrow;
      if (i_RST) begin
         m_reset();
         return;
      end
      old_reload = m_reload;
      borrow     = 0;
      if (i_LD) m_reload = int'(i_D);
      if (m_running) begin
         if (i_STOP) m_running = 0;
         else if (i_START) begin
            m_running = 0;
            m_armed   = 1;
         end else if (i_CNT) begin
            if (m_q > 0) m_q = m_q - 1;
            else begin
               borrow = 1;
               if (i_AUTORELOAD) m_q = old_reload;
               else m_running = 0;
            end
         end
      end else if (m_armed) begin
         m_q       = i_LD ? int'(i_D) : old_reload;
         m_armed   = 0;
         m_running = !i_STOP;
      end else if (i_START && !i_STOP) begin
         m_armed = 1;
      end
      if (i_FLAG_CLR) m_flag = 0;
      else if (borrow && i_IRQ_EN) m_flag = 1;
   endtask

   task automatic m_ncen();
      if (i_RST) m_reset();
      else m_zero = (m_q == 0);
   endtask

   task automatic pslot();
      i_PCEN_n = 1'b0;
      @(posedge clk);
      #1;
      m_pcen();
      i_PCEN_n = 1'b1;
   endtask

   task automatic nslot();
      i_NCEN_n = 1'b0;
      @(posedge clk);
      #1;
      m_ncen();
      i_NCEN_n = 1'b1;
   endtask

   task automatic cycle();
      pslot();
      nslot();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_q",     o_Q,     m_q);
         chk("model_run",   o_RUN,   m_running);
         chk("model_flag",  o_FLAG,  m_flag);
         chk("model_irq_n", o_IRQ_n, !m_flag);
         chk("model_bo",    o_BO,    m_zero && i_CNT && m_running);
      end
   end

   int ar_q[7]    = '{2, 1, 0, 3, 2, 1, 0};
   int ar_bo[7]   = '{0, 0, 1, 0, 0, 0, 1};
   int ar_flag[7] = '{0, 0, 0, 1, 1, 1, 1};
   int os_q[5]    = '{1, 0, 0, 0, 0};
   int os_run[5]  = '{1, 1, 0, 0, 0};
   int os_bo[5]   = '{0, 1, 0, 0, 0};
   int zero_idx[2];
   int n_zero;

   initial begin
      i_RST = 1'b1; i_PCEN_n = 1'b1; i_NCEN_n = 1'b1; i_CNT = 1'b0; i_LD = 1'b0;
      i_D = '0; i_START = 1'b0; i_STOP = 1'b0; i_AUTORELOAD = 1'b0;
      i_IRQ_EN = 1'b0; i_FLAG_CLR = 1'b0;
      m_reset();
      cycle();
      i_RST  = 1'b0;
      chk_en = 1;
      chk("rst_q", o_Q, 0);
      chk("rst_run", o_RUN, 0);
      chk("rst_flag", o_FLAG, 0);
      chk("rst_irq_n", o_IRQ_n, 1);
      chk("rst_bo", o_BO, 0);

      // auto-reload period with reload=3
      i_LD = 1; i_D = 3; i_START = 1; i_CNT = 1; i_AUTORELOAD = 1; i_IRQ_EN = 1;
      cycle();
      i_LD = 0; i_START = 0;
      cycle();
      chk("ar_load_q", o_Q, 3);
      chk("ar_run", o_RUN, 1);
      for (int i = 0; i < 7; i++) begin
         cycle();
         chk("ar_q", o_Q, ar_q[i]);
         chk("ar_bo", o_BO, ar_bo[i]);
         chk("ar_flag", o_FLAG, ar_flag[i]);
      end
      chk("ar_irq_n", o_IRQ_n, 0);
      i_STOP = 1;
      cycle();
      i_STOP = 0; i_FLAG_CLR = 1;
      cycle();
      i_FLAG_CLR = 0;
      chk("ar_stop_run", o_RUN, 0);
      chk("ar_clr_flag", o_FLAG, 0);

      // one-shot with reload=2
      i_AUTORELOAD = 0; i_LD = 1; i_D = 2; i_START = 1;
      cycle();
      i_LD = 0; i_START = 0;
      cycle();
      chk("os_load_q", o_Q, 2);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("os_q", o_Q, os_q[i]);
         chk("os_run", o_RUN, os_run[i]);
         chk("os_bo", o_BO, os_bo[i]);
      end
      chk("os_flag", o_FLAG, 1);
      i_FLAG_CLR = 1;
      cycle();
      i_FLAG_CLR = 0;

      // start and stop together from idle
      i_START = 1; i_STOP = 1;
      cycle();
      cycle();
      i_START = 0; i_STOP = 0;
      cycle();
      chk("prio_run", o_RUN, 0);
      chk("prio_q", o_Q, 0);

      // flag clear beats a simultaneous borrow
      i_AUTORELOAD = 1; i_LD = 1; i_D = 1; i_START = 1;
      cycle();
      i_LD = 0; i_START = 0;
      cycle();
      cycle();
      chk("clr_pre_q", o_Q, 0);
      i_FLAG_CLR = 1;
      cycle();
      i_FLAG_CLR = 0;
      chk("clr_reload_q", o_Q, 1);
      chk("clr_flag", o_FLAG, 0);
      i_STOP = 1;
      cycle();
      i_STOP = 0;

      // stop at 6, restart reloads, count gaps
      i_LD = 1; i_D = 9; i_START = 1;
      cycle();
      i_LD = 0; i_START = 0;
      cycle();
      for (int i = 0; i < 3; i++) cycle();
      chk("sr_q6", o_Q, 6);
      i_STOP = 1;
      cycle();
      i_STOP = 0;
      chk("sr_stop_q", o_Q, 6);
      chk("sr_stop_run", o_RUN, 0);
      cycle();
      chk("sr_hold_q", o_Q, 6);
      i_START = 1;
      cycle();
      i_START = 0;
      chk("sr_arm_q", o_Q, 6);
      cycle();
      chk("sr_reload_q", o_Q, 9);
      chk("sr_run", o_RUN, 1);
      i_CNT = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("gap_q", o_Q, 9);
         chk("gap_bo", o_BO, 0);
      end
      i_CNT = 1;
      cycle();
      chk("gap_resume_q", o_Q, 8);

      // reset aborts a running count at 5
      for (int i = 0; i < 3; i++) cycle();
      chk("mid_pre_q", o_Q, 5);
      i_RST = 1;
      cycle();
      i_RST = 0;
      chk("mid_rst_q", o_Q, 0);
      chk("mid_rst_run", o_RUN, 0);
      chk("mid_rst_bo", o_BO, 0);
      chk("mid_rst_flag", o_FLAG, 0);

      // reload=0 borrows every slot
      i_LD = 1; i_D = 0; i_START = 1;
      cycle();
      i_LD = 0; i_START = 0;
      cycle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("r0_bo", o_BO, 1);
         chk("r0_q", o_Q, 0);
         chk("r0_run", o_RUN, 1);
      end
      chk("r0_flag", o_FLAG, 1);
      i_STOP = 1;
      cycle();
      i_STOP = 0; i_FLAG_CLR = 1;
      cycle();
      i_FLAG_CLR = 0;

      // reload=15 gives a 16-slot period
      i_LD = 1; i_D = 15; i_START = 1;
      cycle();
      i_LD = 0; i_START = 0;
      cycle();
      chk("r15_load_q", o_Q, 15);
      n_zero = 0;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         if (o_Q == 0 && n_zero < 2) begin
            zero_idx[n_zero] = i;
            n_zero++;
         end
      end
      chk("r15_zero_count", n_zero, 2);
      if (n_zero == 2) chk("r15_period", zero_idx[1] - zero_idx[0], 16);
      chk("r15_first_zero", zero_idx[0], 15);

      i_RST = 1;
      cycle();
      i_RST = 0;
      chk("end_rst_flag", o_FLAG, 0);
      chk("end_rst_irq_n", o_IRQ_n, 1);
      chk("end_rst_q", o_Q, 0);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
